sprite_mover: RTL and testbench
===============================

// Module: sprite_mover
// PURPOSE
//   Keyboard-driven sprite motion controller, parametrised in coordinate width, bounds, size, speed.
//   Sampled once per video frame on frame_clk. Turns USB keycodes into heading, accelerating speed
//   and boundary-checked X/Y position. Feeds the sprite renderer (position/size) and rotation logic.
// PARAMETERS
//   W            10   coordinate width (bits)
//   X_MIN        0    leftmost screen X
//   X_MAX        639  rightmost screen X
//   Y_MIN        0    topmost screen Y
//   Y_MAX        479  bottommost screen Y
//   X_CENTER     320  reset X
//   Y_CENTER     240  reset Y
//   SIZE         16   sprite half-extent; centre is kept in [MIN+SIZE, MAX-SIZE]
//   MAX_SPEED    4    saturating speed, pixels/frame
//   ACCEL_FRAMES 8    consecutive held frames per +1 speed
// PORTS
//   frame_clk  in   1  frame clock, one edge per frame
//   Reset      in   1  synchronous, active-high
//   keycode    in   8  current key: 0x1A W=up, 0x16 S=down, 0x04 A=left, 0x07 D=right; other=none
//   PosX       out  W  sprite centre X
//   PosY       out  W  sprite centre Y
//   Size       out  W  constant SIZE
//   Heading    out  2  00 up, 01 right, 10 down, 11 left
//   Moving     out  1  speed != 0 this frame
//   AtEdge     out  4  {left,bottom,right,top}: centre at that bound
// BEHAVIOUR
//   Reset: PosX=X_CENTER, PosY=Y_CENTER, Heading=00, speed=0, accel count=0, state IDLE, Moving=0, AtEdge=0.
//     Reset mid-motion overrides everything on that edge.
//   Registered outputs. A keycode sampled at edge k moves the sprite at edge k (visible after k). Latency 1 frame.
//   FSM, one transition per edge:
//     IDLE   : dir key -> ACCEL, Heading=key dir, speed=1, count=0, move 1 px.
//     ACCEL  : same key -> count+1. At count==ACCEL_FRAMES-1: speed+1, count=0.
//              Speed reaching MAX_SPEED -> CRUISE.
//     CRUISE : same key -> speed=MAX_SPEED.
//     BLOCKED: centre clamped at a bound, speed=0. Key for any other heading -> ACCEL as from IDLE.
//              Same key -> stay. Release -> IDLE.
//     Any moving state: no dir key -> IDLE, speed=0, Heading held.
//       Different dir key -> Heading=new, speed=1, count=0, stay/enter ACCEL (no carried speed).
//   Up: Y-=speed. Down: Y+=speed. Left: X-=speed. Right: X+=speed. Y grows downward.
//   Arithmetic: next position computed signed at W+2 bits. Never wraps through 0 or 2^W.
//   Clamp (default): if next < MIN+SIZE or > MAX-SIZE, position = that bound, state BLOCKED,
//     the matching AtEdge bit is set. AtEdge bits are combinational compares on the registered position.
//   Unrecognised or simultaneous keycodes (single-byte input) count as "no key".
// CONFIGURATION
//   SPRITE_WRAP_EN defined: crossing a bound wraps to the opposite bound plus overshoot
//     (e.g. right: MIN+SIZE+(next-(MAX-SIZE)-1)). BLOCKED is never entered; speed is preserved.
//     AtEdge bit pulses for exactly the wrap frame.
//   Undefined: clamp/BLOCKED behaviour above.
// STRUCTURE
//   sprite_pkg: heading_e (UP,RIGHT,DOWN,LEFT), state_e (IDLE,ACCEL,CRUISE,BLOCKED),
//     KEY_W/KEY_S/KEY_A/KEY_D constants, key->heading decode function.
//   Sub-module axis_stepper (params W,MIN,MAX,SIZE): pos, signed delta -> next pos, hit_min, hit_max.
//     Clamp or wrap per macro. Instantiated once for X and once for Y.
//   FSM, speed and accel counter stay in sprite_mover.
// TESTING
//   1 Reset, keycode 0x00 for 3 frames -> PosX=320, PosY=240, Heading=00, Moving=0, AtEdge=0.
//   2 Hold 0x07 for 9 frames -> PosX 321..328 over frames 1-8, then 330 (speed 2). Heading=01.
//   3 Hold 0x07 for 40 frames -> speed saturates at 4, CRUISE. Release -> Moving=0 next frame, PosX frozen.
//   4 Start PosX=20, hold 0x04 -> PosX 19,18,17,16,16. AtEdge=1000, BLOCKED. Press 0x07 -> PosX 17, AtEdge=0.
//   5 In CRUISE right, switch to 0x1A -> Heading=00, PosY-=1 that frame, PosX unchanged.
//     Assert Reset mid-move -> 320,240 next edge.
//   6 SPRITE_WRAP_EN, PosX=622, hold right at speed 2 -> PosX=16, AtEdge[1] high one frame, speed kept.

Source files
------------

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types for the keyboard-driven sprite mover.
// Holds heading/state enums, USB key constants and the key decoder.
package sprite_pkg;

   typedef enum logic [1:0] {
      UP    = 2'b00,
      RIGHT = 2'b01,
      DOWN  = 2'b10,
      LEFT  = 2'b11
   } heading_e;

   typedef enum logic [1:0] {
      IDLE,
      ACCEL,
      CRUISE,
      BLOCKED
   } state_e;

   localparam logic [7:0] KEY_W = 8'h1A;
   localparam logic [7:0] KEY_S = 8'h16;
   localparam logic [7:0] KEY_A = 8'h04;
   localparam logic [7:0] KEY_D = 8'h07;

   typedef struct packed {
      logic     valid;
      heading_e dir;
   } key_t;

   // Anything that is not one of the four movement keys is "no key".
   function automatic key_t key_decode(input logic [7:0] kc);
      key_t k;
      k.valid = 1'b1;
      k.dir   = UP;
      case (kc)
         KEY_W:   k.dir = UP;
         KEY_S:   k.dir = DOWN;
         KEY_A:   k.dir = LEFT;
         KEY_D:   k.dir = RIGHT;
         default: k.valid = 1'b0;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/axis_stepper.sv
// axis_stepper: one coordinate axis. pos + signed delta -> next pos,
// kept inside [MIN+SIZE, MAX-SIZE]. hit_min/hit_max flag a crossing.
// Ports: pos (W), delta (signed W+2), next_pos (W), hit_min, hit_max.
// Build option SPRITE_WRAP_EN: wrap to the opposite bound plus overshoot
// instead of clamping at the bound.
module axis_stepper #(
   parameter int W    = 10,
   parameter int MIN  = 0,
   parameter int MAX  = 639,
   parameter int SIZE = 16
) (
   input  logic [W-1:0]        pos,
   input  logic signed [W+1:0] delta,
   output logic [W-1:0]        next_pos,
   output logic                hit_min,
   output logic                hit_max
);

   localparam logic signed [W+1:0] LO = (W+2)'(MIN + SIZE);
   localparam logic signed [W+1:0] HI = (W+2)'(MAX - SIZE);
`ifdef SPRITE_WRAP_EN
   localparam logic signed [W+1:0] ONE = (W+2)'(1);
`else
   localparam logic [W-1:0] LO_P = W'(MIN + SIZE);
   localparam logic [W-1:0] HI_P = W'(MAX - SIZE);
`endif

   // Two spare bits so the sum can go below 0 or past 2^W without wrapping.
   logic signed [W+1:0] sum;

   assign sum = $signed({2'b00, pos}) + delta;

   always_comb begin
      next_pos = sum[W-1:0];
      hit_min  = 1'b0;
      hit_max  = 1'b0;
      if (sum < LO) begin
         hit_min = 1'b1;
`ifdef SPRITE_WRAP_EN
         next_pos = W'(HI - (LO - sum - ONE));
`else
         next_pos = LO_P;
`endif
      end else if (sum > HI) begin
         hit_max = 1'b1;
`ifdef SPRITE_WRAP_EN
         next_pos = W'(LO + (sum - HI - ONE));
`else
         next_pos = HI_P;
`endif
      end
   end

endmodule

// File: rtl/sprite_mover.sv
// sprite_mover: per-frame keyboard sprite controller (heading, speed, X/Y).
// Ports: frame_clk, Reset (sync, high), keycode[7:0] -> PosX, PosY, Size,
// Heading, Moving, AtEdge {left,bottom,right,top}. Option: SPRITE_WRAP_EN.
module sprite_mover
   import sprite_pkg::*;
#(
   parameter int W            = 10,
   parameter int X_MIN        = 0,
   parameter int X_MAX        = 639,
   parameter int Y_MIN        = 0,
   parameter int Y_MAX        = 479,
   parameter int X_CENTER     = 320,
   parameter int Y_CENTER     = 240,
   parameter int SIZE         = 16,
   parameter int MAX_SPEED    = 4,
   parameter int ACCEL_FRAMES = 8
) (
   input  logic         frame_clk,
   input  logic         Reset,
   input  logic [7:0]   keycode,
   output logic [W-1:0] PosX,
   output logic [W-1:0] PosY,
   output logic [W-1:0] Size,
   output logic [1:0]   Heading,
   output logic         Moving,
   output logic [3:0]   AtEdge
);

   localparam int SW = $clog2(MAX_SPEED + 1);
   localparam int CW = $clog2(ACCEL_FRAMES + 1);
   localparam logic [SW-1:0] MAXS = SW'(MAX_SPEED);
   localparam logic [SW-1:0] ONES = SW'(1);
   localparam logic [CW-1:0] LAST = CW'(ACCEL_FRAMES - 1);

   state_e        state_q, state_n, state_d;
   heading_e      dir_q, dir_n;
   logic [SW-1:0] spd_q, spd_n, spd_d;
   logic [CW-1:0] cnt_q, cnt_n, cnt_d;
   logic [W-1:0]  pos_x, pos_y, nx, ny;
   logic          move, start;
   key_t          key;

   logic signed [W+1:0] mag, dx, dy;
   logic hx_min, hx_max, hy_min, hy_max;

   // Next heading/speed/count before the bounds are applied.
   always_comb begin
      key     = key_decode(keycode);
      state_n = state_q;
      dir_n   = dir_q;
      spd_n   = spd_q;
      cnt_n   = cnt_q;
      move    = 1'b0;
      start   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (key.valid) start = 1'b1;
         end
         ACCEL, CRUISE: begin
            if (!key.valid) begin
               state_n = IDLE;
               spd_n   = '0;
               cnt_n   = '0;
            end else if (key.dir != dir_q) begin
               start = 1'b1;
            end else begin
               move = 1'b1;
               if (state_q == CRUISE) begin
                  spd_n = MAXS;
               end else if (cnt_q == LAST) begin
                  cnt_n = '0;
                  spd_n = spd_q + ONES;
                  if (spd_n == MAXS) state_n = CRUISE;
               end else begin
                  cnt_n = cnt_q + CW'(1);
               end
            end
         end
         BLOCKED: begin
            if (!key.valid) state_n = IDLE;
            else if (key.dir != dir_q) start = 1'b1;
         end
         default: ;
      endcase
      // A fresh key never inherits speed from the previous heading.
      if (start) begin
         dir_n   = key.dir;
         spd_n   = ONES;
         cnt_n   = '0;
         move    = 1'b1;
         state_n = (MAX_SPEED <= 1) ? CRUISE : ACCEL;
      end
   end

   always_comb begin
      mag = $signed({{(W+2-SW){1'b0}}, spd_n});
      dx  = '0;
      dy  = '0;
      if (move) begin
         unique case (dir_n)
            UP:    dy = -mag;
            DOWN:  dy = mag;
            LEFT:  dx = -mag;
            RIGHT: dx = mag;
            default: ;
         endcase
      end
   end

   axis_stepper #(
      .W(W), .MIN(X_MIN), .MAX(X_MAX), .SIZE(SIZE)
   ) u_x (
      .pos(pos_x), .delta(dx), .next_pos(nx),
      .hit_min(hx_min), .hit_max(hx_max)
   );

   axis_stepper #(
      .W(W), .MIN(Y_MIN), .MAX(Y_MAX), .SIZE(SIZE)
   ) u_y (
      .pos(pos_y), .delta(dy), .next_pos(ny),
      .hit_min(hy_min), .hit_max(hy_max)
   );

   always_comb begin
      state_d = state_n;
      spd_d   = spd_n;
      cnt_d   = cnt_n;
`ifndef SPRITE_WRAP_EN
      // Clamped against a bound: stop dead until a new key.
      if (hx_min | hx_max | hy_min | hy_max) begin
         state_d = BLOCKED;
         spd_d   = '0;
         cnt_d   = '0;
      end
`endif
   end

   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state_q <= IDLE;
         dir_q   <= UP;
         spd_q   <= '0;
         cnt_q   <= '0;
         pos_x   <= W'(X_CENTER);
         pos_y   <= W'(Y_CENTER);
      end else begin
         state_q <= state_d;
         dir_q   <= dir_n;
         spd_q   <= spd_d;
         cnt_q   <= cnt_d;
         pos_x   <= nx;
         pos_y   <= ny;
      end
   end

`ifdef SPRITE_WRAP_EN
   // Position never rests on a bound here, so flag the wrap frame itself.
   logic [3:0] wrap_q;

   always_ff @(posedge frame_clk) begin
      if (Reset) wrap_q <= '0;
      else       wrap_q <= {hx_min, hy_max, hx_max, hy_min};
   end

   assign AtEdge = wrap_q;
`else
   assign AtEdge = {pos_x == W'(X_MIN + SIZE),
                    pos_y == W'(Y_MAX - SIZE),
                    pos_x == W'(X_MAX - SIZE),
                    pos_y == W'(Y_MIN + SIZE)};
`endif

   assign PosX    = pos_x;
   assign PosY    = pos_y;
   assign Size    = W'(SIZE);
   assign Heading = dir_q;
   assign Moving  = (spd_q != '0);

endmodule

// File: tb/tb_sprite_mover.sv
// tb_sprite_mover: table vectors, directed corner sequences and random
// key streams checked against a frame-level behavioural model.
module tb_sprite_mover;

   logic       frame_clk = 1'b0;
   logic       Reset = 1'b1;
   logic [7:0] keycode = 8'h00;
   logic [9:0] PosX, PosY, Size;
   logic [1:0] Heading;
   logic       Moving;
   logic [3:0] AtEdge;

   int n_pass = 0;
   int n_tot  = 0;

   sprite_mover dut (
      .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
      .PosX(PosX), .PosY(PosY), .Size(Size), .Heading(Heading),
      .Moving(Moving), .AtEdge(AtEdge)
   );

   always #5 frame_clk = ~frame_clk;

   localparam int LO_X = 16, HI_X = 623, LO_Y = 16, HI_Y = 463;

   // Behavioural model: plain integers, one call per frame.
   int mx, my, mhd, mspd, mcnt;
   bit mblk;
   bit [3:0] mwrap;

   task automatic chk(string nm, int act, int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   function automatic int key_dir(logic [7:0] kc);
      if (kc == 8'h1A) return 0;
      if (kc == 8'h07) return 1;
      if (kc == 8'h16) return 2;
      if (kc == 8'h04) return 3;
      return -1;
   endfunction

   task automatic axis(inout int p, input int d, input int lo,
                       input int hi, output bit lo_hit, output bit hi_hit);
      int n;
      n = p + d;
      lo_hit = 0;
      hi_hit = 0;
      if (n < lo) begin
         lo_hit = 1;
`ifdef SPRITE_WRAP_EN
         p = hi - (lo - n - 1);
`else
         p = lo;
`endif
      end else if (n > hi) begin
         hi_hit = 1;
`ifdef SPRITE_WRAP_EN
         p = lo + (n - hi - 1);
`else
         p = hi;
`endif
      end else begin
         p = n;
      end
   endtask

   task automatic model_step(logic [7:0] kc, logic rst);
      int k;
      bit go, a, b, c, d;
      if (rst) begin
         mx = 320; my = 240; mhd = 0; mspd = 0; mcnt = 0;
         mblk = 0; mwrap = 0;
         return;
      end
      k = key_dir(kc);
      go = 0;
      mwrap = 0;
      if (k < 0) begin
         mspd = 0; mcnt = 0; mblk = 0;
      end else if (k != mhd || (mspd == 0 && !mblk)) begin
         mhd = k; mspd = 1; mcnt = 0; mblk = 0; go = 1;
      end else if (!mblk) begin
         if (mspd < 4) begin
            if (mcnt == 7) begin
               mspd++;
               mcnt = 0;
            end else begin
               mcnt++;
            end
         end
         go = 1;
      end
      if (go) begin
         a = 0; b = 0; c = 0; d = 0;
         case (mhd)
            0: axis(my, -mspd, LO_Y, HI_Y, a, b);
            2: axis(my, mspd, LO_Y, HI_Y, a, b);
            3: axis(mx, -mspd, LO_X, HI_X, c, d);
            default: axis(mx, mspd, LO_X, HI_X, c, d);
         endcase
         mwrap = {c, b, d, a};
`ifndef SPRITE_WRAP_EN
         if (a | b | c | d) begin
            mblk = 1; mspd = 0; mcnt = 0;
         end
`endif
      end
   endtask

   function automatic logic [3:0] model_edge();
`ifdef SPRITE_WRAP_EN
      return mwrap;
`else
      return {mx == LO_X, my == HI_Y, mx == HI_X, my == LO_Y};
`endif
   endfunction

   task automatic apply(logic [7:0] kc, logic rst);
      keycode = kc;
      Reset = rst;
      model_step(kc, rst);
      @(posedge frame_clk);
      #1;
   endtask

   task automatic chk_model(string tag);
      chk({tag, ".x"}, int'(PosX), mx);
      chk({tag, ".y"}, int'(PosY), my);
      chk({tag, ".hd"}, int'(Heading), mhd);
      chk({tag, ".mv"}, int'(Moving), int'(mspd != 0));
      chk({tag, ".edge"}, int'(AtEdge), int'(model_edge()));
   endtask

   typedef struct {
      logic       rst;
      logic [7:0] kc;
      int         x, y, hd, mv;
      logic [3:0] at;
   } vec_t;

   vec_t tv[16];

   initial begin
      int px, py;
      int exp_a[5];
      bit hit;
      logic [7:0] keys[6];

      tv[0] = '{1'b1, 8'h00, 320, 240, 0, 0, 4'h0};
      for (int i = 1; i < 4; i++) tv[i] = '{1'b0, 8'h00, 320, 240, 0, 0, 4'h0};
      for (int i = 4; i < 13; i++)
         tv[i] = '{1'b0, 8'h07, (i < 12) ? 317 + i : 330, 240, 1, 1, 4'h0};
      tv[13] = '{1'b0, 8'h00, 330, 240, 1, 0, 4'h0};
      tv[14] = '{1'b0, 8'h05, 330, 240, 1, 0, 4'h0};
      tv[15] = '{1'b0, 8'h16, 330, 241, 2, 1, 4'h0};

      for (int i = 0; i < 16; i++) begin
         apply(tv[i].kc, tv[i].rst);
         chk($sformatf("tv%0d.x", i), int'(PosX), tv[i].x);
         chk($sformatf("tv%0d.y", i), int'(PosY), tv[i].y);
         chk($sformatf("tv%0d.hd", i), int'(Heading), tv[i].hd);
         chk($sformatf("tv%0d.mv", i), int'(Moving), tv[i].mv);
         chk($sformatf("tv%0d.edge", i), int'(AtEdge), int'(tv[i].at));
      end
      chk("size", int'(Size), 16);

      // Saturate to cruise, then release.
      apply(8'h00, 1'b0);
      for (int i = 0; i < 40; i++) begin
         px = int'(PosX);
         apply(8'h07, 1'b0);
         chk_model("hold_d");
      end
      chk("cruise_step", int'(PosX) - px, 4);
      px = int'(PosX);
      apply(8'h00, 1'b0);
      chk("rel.mv", int'(Moving), 0);
      chk("rel.x", int'(PosX), px);
      apply(8'h00, 1'b0);
      chk("rel2.x", int'(PosX), px);

`ifndef SPRITE_WRAP_EN
      // Left clamp starting from X=20.
      hit = 0;
      for (int i = 0; i < 300 && !hit; i++) begin
         apply(8'h04, 1'b0);
         chk_model("to_left");
         hit = mblk;
      end
      chk("reach_left", int'(hit), 1);
      for (int i = 0; i < 4; i++) apply(8'h07, 1'b0);
      apply(8'h00, 1'b0);
      chk("start20", int'(PosX), 20);
      exp_a = '{19, 18, 17, 16, 16};
      for (int i = 0; i < 5; i++) begin
         apply(8'h04, 1'b0);
         chk($sformatf("clamp%0d.x", i), int'(PosX), exp_a[i]);
         chk($sformatf("clamp%0d.edge", i), int'(AtEdge),
             (i >= 3) ? 8 : 0);
      end
      chk("blocked.mv", int'(Moving), 0);
      apply(8'h04, 1'b0);
      chk("blocked_hold.x", int'(PosX), 16);
      apply(8'h07, 1'b0);
      chk("unblock.x", int'(PosX), 17);
      chk("unblock.edge", int'(AtEdge), 0);
`else
      // Wrap off the right edge.
      hit = 0;
      for (int i = 0; i < 300 && !hit; i++) begin
         apply(8'h07, 1'b0);
         chk_model("to_right");
         hit = mwrap[1];
      end
      chk("wrap_seen", int'(hit), 1);
      chk("wrap.edge", int'(AtEdge), 2);
      chk("wrap.mv", int'(Moving), 1);
      apply(8'h07, 1'b0);
      chk("wrap_after.edge", int'(AtEdge), 0);
      chk_model("wrap_after");
`endif

      // Cruise right, then turn up; then reset mid-move.
      for (int i = 0; i < 30; i++) begin
         apply(8'h07, 1'b0);
         chk_model("cruise5");
      end
      px = int'(PosX);
      py = int'(PosY);
      apply(8'h1A, 1'b0);
      chk("turn.hd", int'(Heading), 0);
      chk("turn.y", int'(PosY), py - 1);
      chk("turn.x", int'(PosX), px);
      apply(8'h1A, 1'b0);
      apply(8'h1A, 1'b1);
      chk("rst_mid.x", int'(PosX), 320);
      chk("rst_mid.y", int'(PosY), 240);
      chk("rst_mid.hd", int'(Heading), 0);
      chk("rst_mid.mv", int'(Moving), 0);

      // Random key streams against the model.
      keys = '{8'h00, 8'h1A, 8'h16, 8'h04, 8'h07, 8'hFF};
      for (int s = 0; s < 80; s++) begin
         logic [7:0] kc;
         int len;
         kc = keys[$urandom_range(0, 5)];
         if (kc == 8'hFF) kc = 8'($urandom());
         len = $urandom_range(1, 40);
         for (int f = 0; f < len; f++) begin
            apply(kc, ($urandom_range(0, 199) == 0));
            chk_model("rand");
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
